// File: rtl/gng_pkg.sv
`default_nettype none
//==============================================================================
// Module      : gng_pkg
// Description : Shared widths, fixed-point constants, saturation limits and the
//               round/offset/saturate helper for the Gaussian noise scaler.
// Revision    : 1.0 - initial release
//==============================================================================
package gng_pkg;

  // Sample format s<16,11>, scale format u<16,12>
  localparam int SAMPLE_W   = 16;
  localparam int DATA_FRAC  = 11;
  localparam int SIGMA_FRAC = 12;

  // Full-precision product: s<16,11> * u<16,12> -> s<33,23>
  localparam int PROD_W     = SAMPLE_W + SAMPLE_W + 1;

  localparam logic [SAMPLE_W-1:0] SIGMA_ONE   = 16'h1000;
  localparam logic [SAMPLE_W-1:0] MU_ZERO     = 16'h0000;
  localparam logic [SAMPLE_W-1:0] SAT_POS     = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_NEG     = 16'h8000;
  localparam logic [SAMPLE_W-1:0] SAT_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                sat;
  } scaled_t;

  // Round the s<33,23> product to 11 fraction bits (half toward +inf),
  // add the offset and clamp to the 16-bit sample range.
  function automatic scaled_t round_add_sat(
    input logic signed [PROD_W-1:0]   prod,
    input logic        [SAMPLE_W-1:0] mu
  );
    logic signed [PROD_W:0] ext;
    logic signed [PROD_W:0] rounded;
    logic signed [PROD_W:0] mu_ext;
    logic signed [PROD_W:0] sum;
    scaled_t                res;
    ext     = {prod[PROD_W-1], prod};
    ext     = ext + (PROD_W+1)'(1 << (SIGMA_FRAC - 1));
    rounded = ext >>> SIGMA_FRAC;
    mu_ext  = {{(PROD_W+1-SAMPLE_W){mu[SAMPLE_W-1]}}, mu};
    sum     = rounded + mu_ext;
    if (sum > (PROD_W+1)'(32767)) begin
      res.data = SAT_POS;
      res.sat  = 1'b1;
    end else if (sum < -(PROD_W+1)'(32768)) begin
      res.data = SAT_NEG;
      res.sat  = 1'b1;
    end else begin
      res.data = sum[SAMPLE_W-1:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gng_fifo.sv
`default_nettype none
//==============================================================================
// Module      : gng_fifo
// Description : First-word-fall-through FIFO with occupancy count. Head data is
//               visible whenever the FIFO is non-empty and reads as zero when
//               empty. A write into a full FIFO is taken when a read happens in
//               the same cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module gng_fifo
  import gng_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign w_do_rd  = rd_en && (r_count != '0);
  assign w_do_wr  = wr_en && ((r_count != C_FULL) || w_do_rd);
  assign rd_valid = (r_count != '0);
  assign rd_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count    = r_count;

  // Storage array; contents are only observable through a valid head
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gng_scaler.sv
`default_nettype none
//==============================================================================
// Module      : gng_scaler
// Description : Scales and offsets Gaussian noise samples:
//               out = sat16(round(gng_data * sigma >> 12) + mu).
//               Two pipeline stages (multiply, round/add/saturate) feed an FWFT
//               output FIFO; upstream is throttled through gng_ce so that no
//               sample is ever dropped.
//               Optional macro GNG_SCALER_SAT_CNT_EN adds the sat_count port.
// Revision    : 1.0 - initial release
//==============================================================================
module gng_scaler
  import gng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        gng_ce,
  input  logic        gng_valid,
  input  logic [15:0] gng_data,
  input  logic        cfg_load,
  input  logic [15:0] sigma,
  input  logic [15:0] mu,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        sat_flag
`ifdef GNG_SCALER_SAT_CNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 2;

  // Shadow configuration
  logic [SAMPLE_W-1:0]      r_sigma_sh;
  logic [SAMPLE_W-1:0]      r_mu_sh;

  // Stage 1: product plus the offset captured with the sample
  logic                     r_v1;
  logic signed [PROD_W-1:0] r_prod1;
  logic [SAMPLE_W-1:0]      r_mu1;

  // Stage 2: finished sample
  logic                     r_v2;
  logic [SAMPLE_W-1:0]      r_data2;
  logic                     r_sat2;

  logic                     r_sat_flag;
  logic                     w_accept;
  logic signed [PROD_W-1:0] w_data_ext;
  logic signed [PROD_W-1:0] w_sigma_ext;
  logic signed [PROD_W-1:0] w_prod;
  scaled_t                  w_scaled;
  logic [AW:0]              w_fifo_count;
  logic [CNT_W-1:0]         w_outstanding;

  // Everything accepted but not yet delivered counts against the buffer
  assign w_outstanding = CNT_W'(w_fifo_count) + CNT_W'(r_v1) + CNT_W'(r_v2);
  assign gng_ce        = !rst && (w_outstanding <= CNT_W'(FIFO_DEPTH - 1));
  assign w_accept      = gng_ce && gng_valid;

  assign w_data_ext  = {{(PROD_W-SAMPLE_W){gng_data[SAMPLE_W-1]}}, gng_data};
  assign w_sigma_ext = {{(PROD_W-SAMPLE_W){1'b0}}, r_sigma_sh};
  assign w_prod      = w_data_ext * w_sigma_ext;
  assign w_scaled    = round_add_sat(r_prod1, r_mu1);
  assign sat_flag    = r_sat_flag;

  // Shadow registers; a sample accepted in the load cycle still sees old values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sigma_sh <= SIGMA_ONE;
      r_mu_sh    <= MU_ZERO;
    end else if (cfg_load) begin
      r_sigma_sh <= sigma;
      r_mu_sh    <= mu;
    end
  end

  // Stage 1: multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_prod1 <= '0;
      r_mu1   <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_prod1 <= w_prod;
        r_mu1   <= r_mu_sh;
      end
    end
  end

  // Stage 2: round, add offset, saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_sat2  <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data2 <= w_scaled.data;
        r_sat2  <= w_scaled.sat;
      end
    end
  end

  // Sticky saturation flag, raised as the saturated sample enters the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_flag <= 1'b0;
    end else if (r_v2 && r_sat2) begin
      r_sat_flag <= 1'b1;
    end
  end

`ifdef GNG_SCALER_SAT_CNT_EN
  logic [SAMPLE_W-1:0] r_sat_cnt;

  // Saturating count of saturated samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (r_v2 && r_sat2 && (r_sat_cnt != SAT_CNT_MAX)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_count = r_sat_cnt;
`endif

  gng_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (r_v2),
    .wr_data  (r_data2),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .count    (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_gng_scaler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_gng_scaler
// Description : Self-checking bench for gng_scaler: behavioural model with an
//               ordered queue of accepted samples plus directed literal cases.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_gng_scaler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gng_ce;
  logic        gng_valid;
  logic [15:0] gng_data;
  logic        cfg_load;
  logic [15:0] sigma;
  logic [15:0] mu;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        sat_flag;
`ifdef GNG_SCALER_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  gng_scaler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .gng_ce    (gng_ce),
    .gng_valid (gng_valid),
    .gng_data  (gng_data),
    .cfg_load  (cfg_load),
    .sigma     (sigma),
    .mu        (mu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
`ifdef GNG_SCALER_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  typedef struct {
    logic [15:0] data;
    bit          sat;
    int          acc;
    bit          has_lit;
    logic [15:0] lit;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          n_acc  = 0;
  int          n_pop  = 0;
  logic [15:0] m_sigma = 16'h1000;
  logic [15:0] m_mu    = 16'h0000;
  bit          m_flag  = 1'b0;
  int          m_cnt   = 0;
  bit          last_acc;
  bit          want_lit = 1'b0;
  logic [15:0] lit_val  = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact product, floor((p + 2^11) / 2^12) + mu, clamp
  function automatic void model(input logic [15:0] d, input logic [15:0] s,
                                input logic [15:0] m, output logic [15:0] o,
                                output bit sat);
    longint p, r, v;
    p = longint'($signed(d)) * longint'(s);
    r = (p + 2048) >>> 12;
    v = r + longint'($signed(m));
    sat = 1'b0;
    if (v > 32767) begin
      o = 16'h7FFF; sat = 1'b1;
    end else if (v < -32768) begin
      o = 16'h8000; sat = 1'b1;
    end else begin
      o = v[15:0];
    end
  endfunction

  // One clock: compare outputs against the model, then advance the model
  task automatic step();
    bit          exp_ce, exp_valid, pop;
    logic [15:0] o;
    bit          s;
    ent_t        e;
    #1;
    exp_ce    = !rst && (q.size() <= DEPTH - 1);
    exp_valid = (q.size() > 0) && (q[0].acc + 2 <= edge_n);
    check("gng_ce", 32'(gng_ce), 32'(exp_ce));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) check("out_data", 32'(out_data), 32'(q[0].data));
    check("sat_flag", 32'(sat_flag), 32'(m_flag));
`ifdef GNG_SCALER_SAT_CNT_EN
    check("sat_count", 32'(sat_count), 32'(m_cnt));
`endif
    pop      = exp_valid && out_ready;
    last_acc = exp_ce && gng_valid;
    if (pop && q[0].has_lit) check("literal_out", 32'(out_data), 32'(q[0].lit));
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q.delete();
      m_sigma = 16'h1000; m_mu = 16'h0000; m_flag = 1'b0; m_cnt = 0;
      last_acc = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (last_acc) begin
        model(gng_data, m_sigma, m_mu, o, s);
        e.data = o; e.sat = s; e.acc = edge_n; e.has_lit = want_lit; e.lit = lit_val;
        q.push_back(e);
        n_acc++;
      end
      if (cfg_load) begin
        m_sigma = sigma; m_mu = mu;
      end
      foreach (q[i]) begin
        if (q[i].acc + 2 == edge_n && q[i].sat) begin
          m_flag = 1'b1;
          if (m_cnt < 16'hFFFF) m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input logic [15:0] s, input logic [15:0] m);
    sigma = s; mu = m; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] lit);
    bit done = 1'b0;
    gng_valid = 1'b1; gng_data = d; want_lit = 1'b1; lit_val = lit;
    for (int g = 0; g < 50 && !done; g++) begin
      step();
      done = last_acc;
    end
    if (!done) begin
      errors++;
      $display("FAIL send_timeout actual=no_accept expected=accept data=%h", d);
    end
    gng_valid = 1'b0; want_lit = 1'b0;
  endtask

  initial begin
    int a0, p0;
    rst = 1'b1; gng_valid = 1'b0; gng_data = '0; cfg_load = 1'b0;
    sigma = 16'h1000; mu = 16'h0000; out_ready = 1'b1;
    @(negedge clk);
    idle(2);
    #1;
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_gng_ce", 32'(gng_ce), 32'h0);
    rst = 1'b0;
    #1;
    check("ce_after_reset", 32'(gng_ce), 32'h1);

    // Unity gain
    send(16'h0800, 16'h0800);
    idle(4);
    check("no_sat_unity", 32'(sat_flag), 32'h0);

    // Saturation in both directions
    cfg(16'h2000, 16'h0000);
    send(16'h7000, 16'h7FFF);
    send(16'h8000, 16'h8000);
    idle(5);
    check("sat_flag_lit", 32'(sat_flag), 32'h1);
`ifdef GNG_SCALER_SAT_CNT_EN
    check("sat_count_lit", 32'(sat_count), 32'h2);
`endif

    // Rounding half toward +inf
    cfg(16'h0800, 16'h0000);
    send(16'h0001, 16'h0001);
    send(16'hFFFF, 16'h0000);
    idle(5);

    // Configuration change between two accepts
    cfg(16'h1000, 16'h0000);
    send(16'h0100, 16'h0100);
    cfg(16'h1000, 16'h0400);
    send(16'h0100, 16'h0500);
    idle(5);

    // Backpressure: buffer fills, upstream throttled, then full throughput
    cfg(16'h1000, 16'h0000);
    out_ready = 1'b0; gng_valid = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      gng_data = 16'($urandom);
      step();
    end
    check("accepts_under_stall", 32'(n_acc - a0), 32'd4);
    out_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      gng_data = 16'($urandom);
      step();
    end
    check("pops_after_release", 32'(n_pop - p0), 32'd20);
    gng_valid = 1'b0;
    idle(6);

    // Reset with a full buffer and the sticky flag set
    cfg(16'h2000, 16'h0000);
    send(16'h7000, 16'h7FFF);
    out_ready = 1'b0; gng_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      gng_data = 16'($urandom);
      step();
    end
    gng_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_sat_flag", 32'(sat_flag), 32'h0);
    out_ready = 1'b1;
    idle(10);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      gng_valid = ($urandom_range(0, 3) != 0);
      gng_data  = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_load  = ($urandom_range(0, 29) == 0);
      sigma     = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h1800)) : 16'($urandom);
      mu        = 16'($urandom);
      step();
    end
    rst = 1'b0; cfg_load = 1'b0; gng_valid = 1'b0; out_ready = 1'b1;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gng_scaler.md
GNG_SCALER -- requirements
Module: gng_scaler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port gng_ce  output  1  clock enable driven to the upstream Gaussian noise generator.
REQ-005 SHALL have port gng_valid  input  1  upstream sample valid.
REQ-006 SHALL have port gng_data  input  16  upstream sample, s<16,11>.
REQ-007 SHALL have port cfg_load  input  1  one-cycle strobe; captures sigma and mu.
REQ-008 SHALL have port sigma  input  16  scale factor, u<16,12>.
REQ-009 SHALL have port mu  input  16  offset, s<16,11>.
REQ-010 SHALL have port out_valid  output  1  output sample valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_data  output  16  scaled sample, s<16,11>.
REQ-013 SHALL have port sat_flag  output  1  sticky: any saturation since reset.

Function
REQ-014 SHALL accept an upstream sample only in a cycle where gng_ce and gng_valid are both 1.
REQ-015 SHALL use shadow registers for sigma and mu, loaded on cfg_load; a load affects only samples accepted on later cycles.
REQ-016 SHALL compute out = sat16(round(gng_data * sigma_sh >> 12) + mu_sh), with full-precision s<33,23> product and rounding half toward +inf at bit 11.
REQ-017 SHALL saturate to 0x7FFF / 0x8000 on overflow and set sat_flag for that sample.
REQ-018 SHALL use two pipeline stages (multiply, round/add/saturate) followed by a first-word-fall-through FIFO of FIFO_DEPTH.
REQ-019 SHALL present a sample accepted at edge k with out_valid=1 in the cycle after edge k+2 when the FIFO is empty (latency 3).
REQ-020 SHALL transfer an output only on out_valid && out_ready; out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive gng_ce = 1 only when FIFO occupancy + in-flight pipeline samples <= FIFO_DEPTH-1, so no sample is ever dropped.
REQ-022 SHALL support a simultaneous FIFO write and read when full: occupancy is unchanged and no data is lost.
REQ-023 SHALL preserve sample order end to end.

Reset
REQ-024 On rst: gng_ce=0, out_valid=0, out_data=0, sat_flag=0, FIFO empty, pipeline valids cleared, sigma_sh=0x1000, mu_sh=0x0000.
REQ-025 SHALL drop in-flight and buffered samples on rst asserted mid-operation; gng_ce SHALL return to 1 on the first cycle after rst deasserts.

Configuration
REQ-026 With GNG_SCALER_SAT_CNT_EN defined, SHALL add port sat_count  output  16: saturating count of saturated samples, reset to 0, held at 0xFFFF.
REQ-027 Without GNG_SCALER_SAT_CNT_EN, the sat_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package gng_pkg SHALL hold the sample width (16), fraction widths (11, 12), SIGMA_ONE = 0x1000, and the saturation constants.
REQ-029 The FIFO SHALL be a separate sub-module, gng_fifo (FWFT, parameterised width/depth, count output).

Verification
REQ-030 sigma=0x1000, mu=0, gng_data=0x0800 -> out_data=0x0800 three cycles after accept; sat_flag=0.
REQ-031 sigma=0x2000, gng_data=0x7000 -> out_data=0x7FFF, sat_flag=1; gng_data=0x8000 -> 0x8000 (with the macro on, sat_count=2).
REQ-032 sigma=0x0800, mu=0: gng_data=0x0001 -> 0x0001; gng_data=0xFFFF -> 0x0000 (rounding).
REQ-033 Continuous gng_valid, out_ready=0 for 20 cycles -> gng_ce falls after 4 accepts; on release, exactly 4 samples emerge in order, then throughput is 1 sample/cycle.
REQ-034 cfg_load mu=0x0400 between two accepts -> first sample unaffected, second offset by +0.5.
REQ-035 rst pulsed with FIFO full -> out_valid=0 next cycle, sat_flag=0, and no stale sample is emitted afterward.
